// File: rtl/seq_mul32.sv
// seq_mul32: iterative shift-add unsigned multiplier for the execute stage.
// Produces a 2*WIDTH-bit product one multiplier bit per cycle, borrowing the
// shared ripple adder (add_a/add_b/add_sub out, add_sum/add_cout back in)
// instead of owning one.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                abort any operation in flight (synchronous)
//   in_valid/in_ready    operand handshake, op_a (multiplicand), op_b (multiplier)
//   out_valid/out_ready  product handshake, prod_hi/prod_lo
//   busy                 high while iterating
//   add_a/add_b/add_sub  operands/control driven to the shared adder
//   add_sum/add_cout     result returned by the shared adder
module seq_mul32 #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  // One extra bit so count can sit at WIDTH after the last step without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic [CNT_W-1:0]   count;
  logic               zero_op;
  logic               last_step;

  assign zero_op   = ZERO_SKIP && ((op_a == '0) || (op_b == '0));
  assign last_step = (count == CNT_W'(WIDTH - 1));

  // The accumulator doubles as the product register; it only moves in IDLE
  // (load) and RUN (step), so it is stable for the whole of DONE.
  assign prod_hi = acc_hi;
  assign prod_lo = acc_lo;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = zero_op ? DONE : RUN;
      end
      RUN: begin
        busy  = 1'b1;
        add_a = acc_hi;
        add_b = acc_lo[0] ? mcand : '0;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Flush wins over everything but reset; a coincident in_valid is dropped.
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= op_a;
            acc_hi <= '0;
            acc_lo <= zero_op ? '0 : op_b;
            count  <= '0;
          end
        end
        RUN: begin
          // Shift right by one with the adder result entering from the top;
          // add_cout becomes the new MSB so no carry is ever lost.
          {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
          count            <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
